// File: rtl/vc_bus_pkg.sv
// Shared types and widths for the CPU-side write buffer in front of the pin
// sequencer.
//   AW/DW/MW : word-address, data and byte-mask widths
//   state_t  : memory-side FSM state (IDLE, WR, RD)
//   wentry_t : one buffered write {addr, mask, data}
package vc_bus_pkg;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } wentry_t;
endpackage

// File: rtl/vc_wbuf_if.sv
// Bus bundles around the write buffer.
//   vc_cpu_if : CPU side. master = CPU, slave = write buffer.
//     raddr/rreq -> rdata/rdone ; waddr/wmask/wdata -> wdone
//   vc_mem_if : pin-sequencer side. master = write buffer, slave = sequencer.
//     m_raddr/m_rreq -> m_rdata/m_rdone ; m_waddr/m_wmask/m_wdata -> m_wdone
//
// Handshake semantics (both bundles): a request (rreq, or a nonzero wmask)
// is a level held by the requester until the matching one-cycle done pulse.
// The responder ignores a request in any cycle where its own done output is
// high, so a requester that drops the level on seeing done never gets a
// duplicate. On the memory side the buffer masks its request off
// combinationally while the done pulse is present for the same reason.
interface vc_cpu_if;
  import vc_bus_pkg::*;
  logic [AW-1:0] raddr;
  logic          rreq;
  logic [DW-1:0] rdata;
  logic          rdone;
  logic [AW-1:0] waddr;
  logic [MW-1:0] wmask;
  logic [DW-1:0] wdata;
  logic          wdone;

  modport master (output raddr, rreq, waddr, wmask, wdata,
                  input  rdata, rdone, wdone);
  modport slave  (input  raddr, rreq, waddr, wmask, wdata,
                  output rdata, rdone, wdone);
endinterface

interface vc_mem_if;
  import vc_bus_pkg::*;
  logic [AW-1:0] m_raddr;
  logic          m_rreq;
  logic [DW-1:0] m_rdata;
  logic          m_rdone;
  logic [AW-1:0] m_waddr;
  logic [MW-1:0] m_wmask;
  logic [DW-1:0] m_wdata;
  logic          m_wdone;

  modport master (output m_raddr, m_rreq, m_waddr, m_wmask, m_wdata,
                  input  m_rdata, m_rdone, m_wdone);
  modport slave  (input  m_raddr, m_rreq, m_waddr, m_wmask, m_wdata,
                  output m_rdata, m_rdone, m_wdone);
endinterface

// File: rtl/vc_wfifo.sv
// Write-buffer FIFO: DEPTH entries of {addr, mask, data}, wrap-around
// read/write pointers plus an occupancy count. DEPTH must be 2 or 4
// (power of two so the pointers wrap by plain overflow).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (empties FIFO)
//   push, push_entry  : store an entry (honoured when not full, or when a
//                       pop happens in the same cycle)
//   pop               : drop the head entry
//   full, empty, head : status and oldest entry
//   ent_addr/ent_valid: every slot's address and whether it holds a live
//                       entry, for read-after-write hazard compare
module vc_wfifo
  import vc_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wentry_t                   push_entry,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output wentry_t                   head,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr,
  output logic [DEPTH-1:0]          ent_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wentry_t       mem_q [DEPTH];
  wentry_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  logic [PW-1:0] off;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO can take a push in the same cycle its head leaves.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    off       = '0;
    ent_addr  = '0;
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, off} < cnt_q);
      ent_addr[i]  = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: liveness comes from the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/vc_wbuf.sv
// CPU write buffer in front of the pin sequencer. CPU writes are posted into
// a small FIFO and acknowledged the next cycle; the memory-side FSM drains
// them in order and interleaves CPU reads, holding a read back while any
// buffered write targets the same word (no forwarding).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   cpu        : CPU-side bundle (slave)
//   mem        : pin-sequencer bundle (master)
//   dbg_state  : current memory-side FSM state
module vc_wbuf
  import vc_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  vc_cpu_if.slave    cpu,
  vc_mem_if.master   mem,
  output state_t     dbg_state
);
  state_t        state_q, state_d;
  logic          rdone_q, rdone_d;
  logic          wdone_q, wdone_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  wentry_t                  push_entry, head;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         ent_valid;
  logic                     rd_pend, hazard;

  assign push_entry = '{addr: cpu.waddr, mask: cpu.wmask, data: cpu.wdata};
  assign pop        = (state_q == ST_WR) && mem.m_wdone;
  // A request is dead in the cycle its own done pulse is out.
  assign push       = (cpu.wmask != '0) && !wdone_q && (!fifo_full || pop);
  assign rd_pend    = cpu.rreq && !rdone_q;

  vc_wfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head),
    .ent_addr   (ent_addr),
    .ent_valid  (ent_valid)
  );

  // Compared against entries already in the FIFO; a write pushed in the
  // same cycle as the read decision is treated as issued after the read.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == cpu.raddr)) hazard = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdone_d     = 1'b0;
    rdata_d     = rdata_q;
    wdone_d     = push;
    mem.m_raddr = cpu.raddr;
    mem.m_rreq  = 1'b0;
    mem.m_waddr = head.addr;
    mem.m_wmask = '0;
    mem.m_wdata = head.data;
    case (state_q)
      ST_IDLE: begin
        // A full FIFO drains first so the CPU is not stalled on writes.
        if (fifo_full)                state_d = ST_WR;
        else if (rd_pend && !hazard)  state_d = ST_RD;
        else if (!fifo_empty)         state_d = ST_WR;
      end
      ST_WR: begin
        mem.m_wmask = mem.m_wdone ? '0 : head.mask;
        if (mem.m_wdone) state_d = ST_IDLE;
      end
      ST_RD: begin
        mem.m_rreq = !mem.m_rdone;
        if (mem.m_rdone) begin
          rdata_d = mem.m_rdata;
          rdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdone_q <= rdone_d;
      wdone_q <= wdone_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu.rdata = rdata_q;
  assign cpu.rdone = rdone_q;
  assign cpu.wdone = wdone_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_vc_wbuf.sv
module tb_vc_wbuf;
  import vc_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vc_cpu_if cpu ();
  vc_mem_if mem ();

  vc_wbuf #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu),
    .mem       (mem),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q [$];     // expected memory writes {addr, mask, data}, CPU order
  logic [32:0] wlog_q [$];    // writes as completed by the sequencer model
  int          wcyc_q [$];    // cycle of each m_wdone
  int          wl_idx = 0;
  logic [15:0] tb_mem [int];

  int lat_w = 2;
  int lat_r = 2;
  bit resp_en = 1'b1;
  int stale_cyc = -1;

  int wcnt = 0, rcnt = 0;
  int rdone_cnt = 0, mask_on_cnt = 0, mrreq_start = -1;
  bit prev_mrreq = 1'b0;
  int gate_seen = 0, gate_bad = 0;

  function automatic logic [15:0] merge(logic [15:0] old, logic [1:0] m, logic [15:0] d);
    merge = old;
    if (m[0]) merge[7:0]  = d[7:0];
    if (m[1]) merge[15:8] = d[15:8];
  endfunction

  function automatic logic [15:0] mem_rd(logic [14:0] a);
    mem_rd = tb_mem.exists(int'(a)) ? tb_mem[int'(a)] : 16'h0000;
  endfunction

  // ---------------- pin-sequencer model + monitors ----------------
  always @(negedge clk) begin
    if (cpu.rdone) rdone_cnt++;
    if (mem.m_wmask != 2'b00) mask_on_cnt++;
    if (mem.m_rreq && !prev_mrreq) mrreq_start = cyc;
    prev_mrreq  = mem.m_rreq;
    mem.m_wdone = 1'b0;
    mem.m_rdone = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
      rcnt = 0;
    end else if (cyc == stale_cyc) begin
      mem.m_wdone = 1'b1;
      mem.m_rdone = 1'b1;
      mem.m_rdata = 16'hDEAD;
    end else if (resp_en) begin
      if (mem.m_wmask != 2'b00) begin
        wcnt++;
        if (wcnt >= lat_w) begin
          mem.m_wdone = 1'b1;
          wcnt = 0;
          wlog_q.push_back({mem.m_waddr, mem.m_wmask, mem.m_wdata});
          wcyc_q.push_back(cyc);
          tb_mem[int'(mem.m_waddr)] = merge(mem_rd(mem.m_waddr), mem.m_wmask, mem.m_wdata);
        end
      end
      if (mem.m_rreq) begin
        rcnt++;
        if (rcnt >= lat_r) begin
          mem.m_rdone = 1'b1;
          mem.m_rdata = mem_rd(mem.m_raddr);
          rcnt = 0;
        end
      end
    end
  end

  // Requests must be masked off while their done pulse is present.
  always @(negedge clk) begin
    #2;
    if (mem.m_wdone || mem.m_rdone) gate_seen++;
    if ((mem.m_wdone && mem.m_wmask != 2'b00) || (mem.m_rdone && mem.m_rreq)) gate_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check + driver tasks ----------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [1:0] m, input logic [15:0] d,
                           input bit keep, output int acc);
    int k;
    bit got;
    cpu.waddr = a; cpu.wmask = m; cpu.wdata = d;
    got = 1'b0; k = 0; acc = -1;
    while (!got && k < 200) begin
      @(posedge clk); #1; k++;
      if (cpu.wdone) begin got = 1'b1; acc = cyc; end
    end
    cpu.wmask = 2'b00;
    if (keep) exp_q.push_back({a, m, d});
    check("wdone_wait", 64'(got), 64'(1));
  endtask

  task automatic cpu_read(input logic [14:0] a, output logic [15:0] d, output int acc);
    int k;
    bit got;
    cpu.raddr = a; cpu.rreq = 1'b1;
    got = 1'b0; k = 0; acc = -1; d = 16'h0;
    while (!got && k < 200) begin
      @(posedge clk); #1; k++;
      if (cpu.rdone) begin got = 1'b1; acc = cyc; d = cpu.rdata; end
    end
    cpu.rreq = 1'b0;
    check("rdone_wait", 64'(got), 64'(1));
  endtask

  task automatic wait_wlog(int n);
    int k;
    k = 0;
    while (wlog_q.size() < n && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check("wlog_wait", 64'(wlog_q.size() >= n), 64'(1));
  endtask

  task automatic check_writes(string tag);
    logic [32:0] e;
    while (exp_q.size() > 0 && wl_idx < wlog_q.size()) begin
      e = exp_q.pop_front();
      check(tag, 64'(wlog_q[wl_idx]), 64'(e));
      wl_idx++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c, acc, a1, a2, a3, racc, base, m0, r0;
    logic [15:0] rd;

    rst_n = 1'b0;
    cpu.raddr = '0; cpu.rreq = 1'b0;
    cpu.waddr = '0; cpu.wmask = '0; cpu.wdata = '0;
    tb_mem[int'(15'h0300)] = 16'hA5A5;
    tb_mem[int'(15'h0200)] = 16'h2222;

    step(3);
    check("rst_state",   64'(dbg_state), 64'(ST_IDLE));
    check("rst_rdone",   64'(cpu.rdone), 64'(0));
    check("rst_wdone",   64'(cpu.wdone), 64'(0));
    check("rst_rdata",   64'(cpu.rdata), 64'(0));
    check("rst_m_wmask", 64'(mem.m_wmask), 64'(0));
    check("rst_m_rreq",  64'(mem.m_rreq), 64'(0));
    rst_n = 1'b1;
    step(2);

    // Single full-word write, slow sequencer.
    lat_w = 6; base = wlog_q.size(); m0 = mask_on_cnt; c = cyc;
    cpu_write(15'h1234, 2'b11, 16'hBEEF, 1'b1, acc);
    check("w1_wdone_cyc", 64'(acc), 64'(c + 1));
    wait_wlog(base + 1);
    check("w1_mwdone_cyc", 64'(wcyc_q[base]), 64'(c + 7));
    step(4);
    check("w1_issue_cycles", 64'(mask_on_cnt - m0), 64'(6));
    check("w1_single", 64'(wlog_q.size()), 64'(base + 1));
    check_writes("w1_content");

    // Three back-to-back writes into a 2-deep buffer.
    lat_w = 6; base = wlog_q.size();
    cpu_write(15'h0011, 2'b11, 16'h0001, 1'b1, a1);
    cpu_write(15'h0022, 2'b11, 16'h0002, 1'b1, a2);
    cpu_write(15'h0033, 2'b11, 16'h0003, 1'b1, a3);
    check("bb_w2_cyc", 64'(a2), 64'(a1 + 2));
    wait_wlog(base + 3);
    check("bb_w3_after_pop", 64'(a3), 64'(wcyc_q[base] + 1));
    check_writes("bb_order");
    step(2);

    // Read of a buffered word waits for the write to reach memory.
    lat_w = 3; lat_r = 2; base = wlog_q.size();
    cpu_write(15'h0100, 2'b11, 16'h1111, 1'b1, acc);
    cpu_read(15'h0100, rd, racc);
    wait_wlog(base + 1);
    check("haz_mrreq_cyc", 64'(mrreq_start), 64'(wcyc_q[base] + 2));
    check("haz_rdata", 64'(rd), 64'(16'h1111));
    check("haz_rdone_cyc", 64'(racc), 64'(mrreq_start + 2));
    check_writes("haz_write");
    step(2);

    // Read of a different word bypasses the buffered write.
    lat_w = 8; lat_r = 2; base = wlog_q.size();
    cpu_write(15'h0100, 2'b11, 16'h3333, 1'b1, acc);
    cpu_read(15'h0200, rd, racc);
    check("nohaz_rdone_cyc", 64'(racc), 64'(acc + 3));
    check("nohaz_rdata", 64'(rd), 64'(16'h2222));
    wait_wlog(base + 1);
    check("nohaz_write_after", 64'(wcyc_q[base] > racc), 64'(1));
    check_writes("nohaz_write");
    step(2);

    // Read latency on an idle buffer, then rdata holds.
    lat_r = 2; c = cyc;
    cpu_read(15'h0300, rd, racc);
    check("rd_mrreq_cyc", 64'(mrreq_start), 64'(c + 1));
    check("rd_rdone_cyc", 64'(racc), 64'(c + 3));
    check("rd_rdata", 64'(rd), 64'(16'hA5A5));
    step(3);
    check("rd_hold", 64'(cpu.rdata), 64'(16'hA5A5));

    // Byte write passes its mask through.
    lat_w = 2; base = wlog_q.size();
    cpu_write(15'h0042, 2'b01, 16'h00AA, 1'b1, acc);
    wait_wlog(base + 1);
    check("byte_mask", 64'(wlog_q[base][17:16]), 64'(2'b01));
    check_writes("byte_write");
    step(2);

    // Reset in the middle of a read with one write buffered.
    lat_w = 50; lat_r = 50;
    cpu_write(15'h0500, 2'b11, 16'h5555, 1'b0, acc);
    cpu.raddr = 15'h0600; cpu.rreq = 1'b1;
    step(3);
    check("mid_state_rd", 64'(dbg_state), 64'(ST_RD));
    rst_n = 1'b0; cpu.rreq = 1'b0;
    step(2);
    lat_w = 2; lat_r = 2;
    r0 = rdone_cnt; m0 = mask_on_cnt; base = wlog_q.size();
    rst_n = 1'b1;
    stale_cyc = cyc;
    step(1);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    step(8);
    check("stale_no_rdone", 64'(rdone_cnt - r0), 64'(0));
    check("flush_no_wreq", 64'(mask_on_cnt - m0), 64'(0));
    check("flush_no_write", 64'(wlog_q.size()), 64'(base));
    check("post_rst_rdata", 64'(cpu.rdata), 64'(0));
    check("post_rst_m_rreq", 64'(mem.m_rreq), 64'(0));
    check("post_rst_idle", 64'(dbg_state), 64'(ST_IDLE));

    check("writes_matched", 64'(wl_idx), 64'(wlog_q.size()));
    check("exp_drained", 64'(exp_q.size()), 64'(0));
    check("gate_violations", 64'(gate_bad), 64'(0));
    check("gate_observed", 64'(gate_seen > 0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_wbuf.md
VC_WBUF -- requirements
Module: vc_wbuf

Interface
REQ-001 Parameter DEPTH, default 2, write-buffer entries; legal values 2 or 4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 raddr  in  15  CPU read word address [15:1].
REQ-005 rreq  in  1  CPU read request; level, held until rdone.
REQ-006 rdata  out  16  read data to CPU, valid while rdone=1.
REQ-007 rdone  out  1  one-cycle read-complete pulse to CPU.
REQ-008 waddr  in  15  CPU write word address.
REQ-009 wmask  in  2  CPU byte-write mask; nonzero = write request, held until wdone.
REQ-010 wdata  in  16  CPU write data.
REQ-011 wdone  out  1  one-cycle write-accepted pulse to CPU.
REQ-012 m_raddr, m_rreq  out  15, 1  read request to pin sequencer.
REQ-013 m_rdata  in  16  read data from pin sequencer, valid with m_rdone.
REQ-014 m_rdone  in  1  one-cycle read-complete pulse from pin sequencer.
REQ-015 m_waddr, m_wmask, m_wdata  out  15, 2, 16  write request to pin sequencer; m_wmask nonzero = request.
REQ-016 m_wdone  in  1  one-cycle write-complete pulse from pin sequencer.

Function
REQ-017 Write buffer: DEPTH-entry FIFO of {waddr, wmask, wdata}; wrap-around pointers plus count.
REQ-018 CPU write with wmask!=0, FIFO not full, wdone=0: push entry; wdone=1 next cycle.
REQ-019 CPU write while FIFO full: not pushed; wdone stays 0 until a slot frees; push in the cycle a pop occurs is allowed (simultaneous push/pop keeps count).
REQ-020 CPU request (rreq or wmask) ignored in any cycle where its own done output is 1.
REQ-021 Memory-side FSM states: IDLE, WR, RD; exactly one outstanding memory operation.
REQ-022 IDLE priority: (a) FIFO full -> WR with head entry; (b) rreq pending, no hazard -> RD; (c) FIFO not empty -> WR; else stay IDLE.
REQ-023 Hazard: raddr equals waddr of any valid FIFO entry; read held back until no matching entry remains (no forwarding).
REQ-024 WR: m_waddr/m_wmask/m_wdata = head entry; on m_wdone pop head, -> IDLE.
REQ-025 RD: m_raddr=raddr, m_rreq=1; on m_rdone capture m_rdata into rdata, rdone=1 next cycle, -> IDLE.
REQ-026 m_wmask forced 0 whenever m_wdone=1, m_rreq forced 0 whenever m_rdone=1 (combinational), so sequencer cannot re-issue.
REQ-027 m_wmask=0 outside WR, m_rreq=0 outside RD.
REQ-028 Read latency, empty FIFO, idle FSM: rreq cycle 0 -> m_rreq cycle 1 -> rdone 1 cycle after m_rdone.
REQ-029 Write acceptance latency: wdone 1 cycle after request when not full, independent of memory side.
REQ-030 rdata holds last captured value between reads.
REQ-031 Writes leave memory in CPU issue order; reads never pass a write to the same word.

Reset
REQ-032 rst_n=0: FSM IDLE, FIFO empty (buffered writes discarded), rdone=0, wdone=0, rdata=0, all m_* requests 0.
REQ-033 Reset mid-operation aborts the outstanding op; a late m_wdone/m_rdone in IDLE is ignored.

Structure
REQ-034 Package vc_bus_pkg: FSM state enum, address width 15, data width 16, mask width 2, FIFO entry struct.
REQ-035 FIFO as sub-module vc_wfifo (push, pop, full, empty, head, per-entry address/valid for hazard compare); FSM and handshakes in vc_wbuf.

Verification
REQ-036 Single write waddr=0x1234 wmask=2'b11 wdata=0xBEEF, sequencer m_wdone 6 cycles after -> wdone cycle 1, m_* shows 0x1234/11/0xBEEF, one issue only.
REQ-037 Three back-to-back writes, DEPTH=2, m_wdone slow -> third wdone delayed until first pop; memory order 1,2,3.
REQ-038 Write 0x0100=0x1111 buffered, then read 0x0100 -> m_rreq only after write m_wdone; rdata=memory value 0x1111.
REQ-039 Write 0x0100 buffered, read 0x0200 -> read issued before write; rdone before write pop.
REQ-040 Reset asserted during RD with 1 write buffered -> after reset FIFO empty, no m_* request, stale m_rdone produces no rdone.
REQ-041 Byte write wmask=2'b01 wdata=0x00AA -> m_wmask=01 passed unchanged.
